// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: select codes, legality check, issue-entry layout.
package alu_pkg;

  localparam int unsigned ALU_DW = 32;
  localparam int unsigned ALU_RW = 5;

  localparam logic [3:0] ALU_HOLD  = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_SUB   = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_NOT   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_SHL   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

  typedef struct packed {
    logic [ALU_DW-1:0] opa;
    logic [ALU_DW-1:0] opb;
    logic [ALU_RW-1:0] srca;
    logic [ALU_RW-1:0] srcb;
    logic [ALU_RW-1:0] dst;
    logic [3:0]        sel;
  } issue_entry_t;

  // HOLD is deliberately not legal: decode must never request it.
  function automatic logic is_legal_sel(input logic [3:0] sel);
    case (sel)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT, ALU_XOR, ALU_SHL, ALU_PASSB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry in-order valid/ready buffer (main + skid), generic over the entry type.
// in_ready_o comes straight from the state register, so it never depends on out_ready_i.
module alu_issue_skid #(
  parameter type EntryT = logic
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  flush_i,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  EntryT in_data_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output EntryT out_data_o
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e state_q, state_d;
  EntryT  main_q, main_d;
  EntryT  skid_q, skid_d;
  logic   accept, issue;

  assign in_ready_o  = (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;
  assign accept      = in_valid_i & in_ready_o;
  assign issue       = out_valid_o & out_ready_i;

  // Next-state and entry movement; flush overrides everything and drops any incoming op.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StBusy;
          main_d  = in_data_i;
        end
      end
      StBusy: begin
        if (accept && !issue) begin
          state_d = StFull;
          skid_d  = in_data_i;
        end else if (accept && issue) begin
          main_d = in_data_i;
        end else if (issue) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (issue) begin
          state_d = StBusy;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // State and entry registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage in front of the ALU: buffers decoded ops, sanitises illegal select
// codes to ADD, forwards the last ALU result into dependent operands and drives HOLD in bubbles.
// Optional: define ALU_ISSUE_FWD_EN to enable result forwarding; otherwise alu_result is unused
// and decode must interlock on dependencies.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = ALU_DW,  // must match the package entry layout
  parameter int unsigned RW = ALU_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_opa,
  input  logic [DW-1:0] in_opb,
  input  logic [RW-1:0] in_srca,
  input  logic [RW-1:0] in_srcb,
  input  logic [RW-1:0] in_dst,
  input  logic [3:0]    in_alusel,
  output logic [DW-1:0] OperandA,
  output logic [DW-1:0] OperandB,
  output logic [3:0]    ALUsel,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [RW-1:0] ex_dst,
  input  logic [DW-1:0] alu_result,
  output logic          illegal_op
);

  issue_entry_t  in_entry, main_entry;
  logic          main_v, accept, in_legal, illegal_q;
  logic [DW-1:0] opa_sel, opb_sel, opa_hold_q, opb_hold_q;

  assign in_legal = is_legal_sel(in_alusel);
  assign accept   = in_valid & in_ready;

  // Pack the incoming op; unsupported codes are stored as ADD.
  always_comb begin
    in_entry      = '0;
    in_entry.opa  = in_opa;
    in_entry.opb  = in_opb;
    in_entry.srca = in_srca;
    in_entry.srcb = in_srcb;
    in_entry.dst  = in_dst;
    in_entry.sel  = in_legal ? in_alusel : ALU_ADD;
  end

  alu_issue_skid #(
    .EntryT(issue_entry_t)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_entry),
    .out_valid_o(main_v),
    .out_ready_i(ex_ready),
    .out_data_o (main_entry)
  );

  assign ex_valid = main_v;
  assign ALUsel   = main_v ? main_entry.sel : ALU_HOLD;
  assign ex_dst   = main_entry.dst;

`ifdef ALU_ISSUE_FWD_EN
  logic          issue, fwd_v_q;
  logic [DW-1:0] fwd_data_q;
  logic [RW-1:0] fwd_dst_q;

  assign issue = ex_valid & ex_ready;

  // Capture the result of each issued op; flush invalidates and blocks the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_v_q    <= 1'b0;
      fwd_data_q <= '0;
      fwd_dst_q  <= '0;
    end else if (flush) begin
      fwd_v_q <= 1'b0;
    end else if (issue) begin
      fwd_v_q    <= 1'b1;
      fwd_data_q <= alu_result;
      fwd_dst_q  <= ex_dst;
    end
  end

  // Operand select; tag 0 never matches so immediates and r0 pass through.
  always_comb begin
    opa_sel = main_entry.opa;
    opb_sel = main_entry.opb;
    if (fwd_v_q && main_entry.srca != '0 && main_entry.srca == fwd_dst_q) opa_sel = fwd_data_q;
    if (fwd_v_q && main_entry.srcb != '0 && main_entry.srcb == fwd_dst_q) opb_sel = fwd_data_q;
  end
`else
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;
  assign opa_sel = main_entry.opa;
  assign opb_sel = main_entry.opb;
`endif

  // Remember the last driven operands so the ALU inputs stay still during bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_hold_q <= '0;
      opb_hold_q <= '0;
    end else if (main_v) begin
      opa_hold_q <= opa_sel;
      opb_hold_q <= opb_sel;
    end
  end

  assign OperandA = main_v ? opa_sel : opa_hold_q;
  assign OperandB = main_v ? opb_sel : opb_hold_q;

  // One-cycle pulse after an unsupported code is accepted; a flushed op does not count.
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= accept & ~flush & ~in_legal;
  end

  assign illegal_op = illegal_q;

endmodule
